// File: rtl/mem_init_pkg.sv
// Shared types and constants for the counter-word memory initiator.
package mem_init_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLEAR  = 3'd1,
    ST_READ   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_GAP    = 3'd4,
    ST_FINISH = 3'd5
  } state_t;

  localparam logic [3:0] WSTRB_READ = 4'h0;
  localparam logic [3:0] WSTRB_WORD = 4'hf;

endpackage

// File: rtl/mem_req_timer.sv
// Request watchdog: down-counter reloaded whenever no request is outstanding,
// flags expiry in the TIMEOUT-th cycle of an unacknowledged request.
module mem_req_timer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic arm,
  input  logic ack,
  output logic expired
);

  localparam logic [31:0] LOAD = (TIMEOUT > 0) ? 32'(TIMEOUT - 1) : 32'd0;

  logic [31:0] cnt;

  // Reload while idle or on acknowledge, otherwise count down to terminal count.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= LOAD;
    end else if (!arm || ack) begin
      cnt <= LOAD;
    end else if (cnt != 32'd0) begin
      cnt <= cnt - 32'd1;
    end
  end

  assign expired = arm && !ack && (cnt == 32'd0);

endmodule

// File: rtl/mem_initiator.sv
// Memory initiator: clears a counter word, then runs read-increment-write
// loops against it, checking each read against the loop count.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | waiting for start
//   ST_CLEAR  | writing 0 to the counter word
//   ST_READ   | reading the counter word
//   ST_WRITE  | writing back captured value + 1
//   ST_GAP    | one idle cycle between requests
//   ST_FINISH | run over (done or error), back to idle next cycle
module mem_initiator
  import mem_init_pkg::*;
#(
  parameter logic [31:0] TARGET_ADDR = 32'd1020,
  parameter logic [31:0] ITERATIONS  = 32'd100,
  parameter int unsigned TIMEOUT     = 16,
  parameter bit          CHECK_DATA  = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        mem_valid,
  output logic        mem_instr,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] iter_count
);

  state_t      state, state_nx;
  logic        gap_to_write, gap_to_write_nx;
  logic [31:0] wr_data_q;
  logic        handshake, expired, data_bad;
  logic        run_start, set_done, set_error, inc_iter, load_wdata;

  // Request outputs decode straight from the state register, so they cannot
  // move while a request is waiting for mem_ready.
  assign mem_valid = (state == ST_CLEAR) || (state == ST_READ) || (state == ST_WRITE);
  assign mem_instr = 1'b0;
  assign mem_addr  = mem_valid ? TARGET_ADDR : 32'd0;
  assign mem_wstrb = ((state == ST_CLEAR) || (state == ST_WRITE)) ? WSTRB_WORD : WSTRB_READ;
  assign mem_wdata = (state == ST_WRITE) ? wr_data_q : 32'd0;
  assign busy      = mem_valid || (state == ST_GAP);
  assign handshake = mem_valid && mem_ready;
  assign data_bad  = CHECK_DATA && (mem_rdata != iter_count);

  mem_req_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .arm    (mem_valid),
    .ack    (handshake),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state and per-cycle control strobes; a handshake wins over expiry.
  always_comb begin
    state_nx        = state;
    gap_to_write_nx = gap_to_write;
    run_start       = 1'b0;
    set_done        = 1'b0;
    set_error       = 1'b0;
    inc_iter        = 1'b0;
    load_wdata      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          run_start = 1'b1;
          state_nx  = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (handshake) begin
          if (ITERATIONS == 32'd0) begin
            set_done = 1'b1;
            state_nx = ST_FINISH;
          end else begin
            gap_to_write_nx = 1'b0;
            state_nx        = ST_GAP;
          end
        end else if (expired) begin
          set_error = 1'b1;
          state_nx  = ST_FINISH;
        end
      end
      ST_READ: begin
        if (handshake) begin
          if (data_bad) begin
            set_error = 1'b1;
            state_nx  = ST_FINISH;
          end else begin
            load_wdata      = 1'b1;
            gap_to_write_nx = 1'b1;
            state_nx        = ST_GAP;
          end
        end else if (expired) begin
          set_error = 1'b1;
          state_nx  = ST_FINISH;
        end
      end
      ST_WRITE: begin
        if (handshake) begin
          inc_iter = 1'b1;
          if ((iter_count + 32'd1) == ITERATIONS) begin
            set_done = 1'b1;
            state_nx = ST_FINISH;
          end else begin
            gap_to_write_nx = 1'b0;
            state_nx        = ST_GAP;
          end
        end else if (expired) begin
          set_error = 1'b1;
          state_nx  = ST_FINISH;
        end
      end
      ST_GAP: begin
        state_nx = gap_to_write ? ST_WRITE : ST_READ;
      end
      ST_FINISH: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Run status, loop counter and write-back data.
  always_ff @(posedge clock) begin
    if (reset) begin
      done         <= 1'b0;
      error        <= 1'b0;
      iter_count   <= 32'd0;
      wr_data_q    <= 32'd0;
      gap_to_write <= 1'b0;
    end else begin
      gap_to_write <= gap_to_write_nx;
      if (run_start) begin
        done       <= 1'b0;
        error      <= 1'b0;
        iter_count <= 32'd0;
      end
      if (set_done) begin
        done <= 1'b1;
      end
      if (set_error) begin
        error <= 1'b1;
      end
      if (inc_iter) begin
        iter_count <= iter_count + 32'd1;
      end
      if (load_wdata) begin
        wr_data_q <= mem_rdata + 32'd1;
      end
    end
  end

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 Parameter TARGET_ADDR, default 32'd1020: byte address of the counter word; word-aligned.
REQ-002 Parameter ITERATIONS, default 32'd100: number of read-increment-write loops after the initial clear.
REQ-003 Parameter TIMEOUT, default 16: maximum cycles mem_valid may stay high without mem_ready.
REQ-004 clock  input  1  sole clock; all state updates on posedge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a run when idle.
REQ-007 mem_valid  output  1  request valid.
REQ-008 mem_instr  output  1  instruction-fetch flag; constant 0.
REQ-009 mem_ready  input  1  responder completion; handshake = mem_valid && mem_ready.
REQ-010 mem_addr  output  32  request byte address.
REQ-011 mem_wdata  output  32  write data.
REQ-012 mem_wstrb  output  4  byte enables; 4'h0 = read, 4'hf = full-word write.
REQ-013 mem_rdata  input  32  read data; valid only in the handshake cycle.
REQ-014 busy  output  1  high from the cycle after an accepted start until done or error.
REQ-015 done  output  1  sticky; run finished without error.
REQ-016 error  output  1  sticky; data mismatch or timeout.
REQ-017 iter_count  output  32  number of completed write-back loops.

Function
REQ-018 States: IDLE, CLEAR, READ, WRITE, GAP, FINISH.
REQ-019 IDLE with start=1 -> CLEAR; mem_valid rises in the next cycle; done/error/iter_count cleared on that transition.
REQ-020 start while not in IDLE is ignored.
REQ-021 CLEAR: write 0 to TARGET_ADDR, mem_wstrb=4'hf.
REQ-022 READ: mem_addr=TARGET_ADDR, mem_wstrb=4'h0; mem_rdata captured in the handshake cycle.
REQ-023 Captured value != iter_count -> error=1, enter FINISH.
REQ-024 WRITE: mem_wdata = captured value + 1, modulo 2^32 (0xFFFFFFFF -> 0); iter_count increments in the WRITE handshake cycle.
REQ-025 mem_addr, mem_wdata, mem_wstrb stable while mem_valid is high and unacknowledged.
REQ-026 After every handshake, mem_valid is 0 for exactly one cycle (GAP), then the next request issues.
REQ-027 Sequence: CLEAR -> READ -> WRITE -> READ ... until iter_count == ITERATIONS after a WRITE, then FINISH with done=1.
REQ-028 ITERATIONS=0: CLEAR handshake -> FINISH, done=1, no READ issued.
REQ-029 Timeout counter resets at each request start; TIMEOUT cycles of mem_valid without mem_ready -> mem_valid drops next cycle, error=1, FINISH.
REQ-030 mem_ready while mem_valid=0 is ignored.
REQ-031 FINISH: busy=0, mem_valid=0; returns to IDLE the next cycle; done/error hold until the next accepted start.

Reset
REQ-032 reset=1 at any posedge forces IDLE; mem_valid, busy, done, error, mem_wstrb, mem_wdata, iter_count = 0; mem_addr = 0.
REQ-033 Reset mid-transaction abandons the request: mem_valid=0 in the cycle after reset is sampled, and no completion is recorded.

Structure
REQ-034 Shared package mem_init_pkg holds the state enum, WSTRB_READ=4'h0, and WSTRB_WORD=4'hf.
REQ-035 Timeout counting lives in sub-module mem_req_timer (inputs: clock, reset, arm, ack; output: expired).

Verification
REQ-036 Single-cycle-latency responder (ready registered one cycle after valid), ITERATIONS=3: writes 0,1,2,3 to 1020; done=1, iter_count=3, error=0.
REQ-037 Responder with random 0-5 cycle ready delay: address, data and strobe held stable; mem_valid low exactly one cycle between requests.
REQ-038 Responder returns 5 instead of 1 on the second read -> error=1, done=0, no further requests.
REQ-039 Responder never asserts ready, TIMEOUT=16 -> error=1 after 16 valid cycles; busy=0.
REQ-040 Responder preloads 0xFFFFFFFF before the first read, check disabled in bench: write-back data is 0x00000000.
REQ-041 reset pulsed while a WRITE is pending, then start -> fresh run beginning with CLEAR; ITERATIONS=0 run yields a single write and done=1.
